// File: rtl/dff_delay_line_if.sv
// Bus interface for dff_delay_line: control, data in, and registered outputs.
// Optional macro DFF_QINV_EN adds the inverted output q_n.
interface dff_delay_line_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
    logic             full;
`ifdef DFF_QINV_EN
    logic [WIDTH-1:0] q_n;

    modport master (
        output en, clr, d, d_valid,
        input  q, q_valid, count, full, q_n
    );

    modport slave (
        input  en, clr, d, d_valid,
        output q, q_valid, count, full, q_n
    );
`else
    modport master (
        output en, clr, d, d_valid,
        input  q, q_valid, count, full
    );

    modport slave (
        input  en, clr, d, d_valid,
        output q, q_valid, count, full
    );
`endif
endinterface

// File: rtl/dff_delay_line.sv
// dff_delay_line: stallable WIDTH x DEPTH register delay line with per-stage valid
// bits, synchronous flush, occupancy count and full flag.
// Optional macro DFF_QINV_EN drives bus.q_n = ~q.
module dff_delay_line #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    dff_delay_line_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_d;
    logic             w_flush;

    // rst and clr have identical effect; rst only wins in priority, which is moot here
    assign w_flush = rst || bus.clr;

    // One word enters and one leaves per advance, so count moves by at most one
    always_comb begin
        w_count_d = r_count + CW'(bus.d_valid) - CW'(r_valid[DEPTH-1]);
    end

    // Data stages: flush to RESET_VAL, otherwise shift on en, else hold
    always_ff @(posedge clk) begin
        if (w_flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else if (bus.en) begin
            r_data[0] <= bus.d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Valid bits and occupancy count advance in lockstep with the data stages
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (bus.en) begin
            r_valid[0] <= bus.d_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            r_count <= w_count_d;
        end
    end

    assign bus.q       = r_data[DEPTH-1];
    assign bus.q_valid = r_valid[DEPTH-1];
    assign bus.count   = r_count;
    assign bus.full    = (r_count == CW'(DEPTH));
`ifdef DFF_QINV_EN
    assign bus.q_n     = ~r_data[DEPTH-1];
`endif

`ifndef SYNTHESIS
    // Count must stay in range and agree with the valid bits it summarises
    a_count_range: assert property (@(posedge clk) r_count <= CW'(DEPTH));
    a_count_match: assert property (@(posedge clk) r_count == CW'($countones(r_valid)));
`endif
endmodule
